// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path: sample width, sample type and
// default decimator/FIFO sizing.
package fir_pkg;

    localparam int unsigned FIR_OUT_W = 11;
    localparam int unsigned DECIM_DEF = 2;
    localparam int unsigned DEPTH_DEF = 8;

    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with separate occupancy count; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rptr];
    assign count   = cnt;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_fifo.sv
// Keeps one of every DECIM qualified filter samples and buffers the kept ones
// for a stallable consumer; a dropped sample raises a sticky overflow flag.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DECIM  = DECIM_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = FIR_OUT_W,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_en,
    output logic signed [DATA_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [CW-1:0]            count,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]     phase;
    logic [PW-1:0]     phase_nxt;
    logic              push_req;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic              ovf_nxt;
    logic [DATA_W-1:0] rdata;

    assign push_req   = din_en && (phase == '0);
    assign dout_valid = !empty;
    assign pop        = dout_valid && dout_ready;
    assign drop       = push_req && full && !pop;
    assign dout       = rdata;

    always_comb begin
        phase_nxt = phase;
        if (din_en) begin
            phase_nxt = (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_nxt = ovf;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            ovf   <= 1'b0;
        end else begin
            phase <= phase_nxt;
            ovf   <= ovf_nxt;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (din),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
